// File: rtl/fp_align_shifter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// fp_align_shifter : binary32 pre-add exponent alignment, 2-stage pipeline
// Rev 1.0
// ============================================================================
module fp_align_shifter #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   in_a,
   input  logic [EXP_W+MAN_W:0]   in_b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [MAN_W:0]         out_man_large,
   output logic [MAN_W:0]         out_man_small,
   output logic [2:0]             out_grs,
   output logic [EXP_W-1:0]       out_exp,
   output logic                   out_sign_large,
   output logic                   out_eff_sub,
   output logic                   out_special
);

   localparam int FP_W  = EXP_W + MAN_W + 1;
   localparam int SIG_W = MAN_W + 1;
   localparam int EXT_W = SIG_W + 3;
   localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

   // ---------------------------------------------------------------- unpack
   logic [EXP_W-1:0] w_fld_a, w_fld_b;
   logic [EXP_W-1:0] w_exp_a, w_exp_b;
   logic [SIG_W-1:0] w_man_a, w_man_b;
   logic             w_swap;

   logic [SIG_W-1:0] s1_man_l_d, s1_man_s_d;
   logic [EXP_W-1:0] s1_exp_d, s1_diff_d;
   logic             s1_sign_d, s1_sub_d, s1_spec_d;

   always_comb begin
      w_fld_a = in_a[FP_W-2 -: EXP_W];
      w_fld_b = in_b[FP_W-2 -: EXP_W];
      // Denormals/zero share the minimum normal exponent with no hidden bit
      w_exp_a = (w_fld_a == '0) ? EXP_ONE : w_fld_a;
      w_exp_b = (w_fld_b == '0) ? EXP_ONE : w_fld_b;
      w_man_a = {|w_fld_a, in_a[MAN_W-1:0]};
      w_man_b = {|w_fld_b, in_b[MAN_W-1:0]};
      w_swap  = {w_exp_b, w_man_b} > {w_exp_a, w_man_a};

      s1_man_l_d = w_swap ? w_man_b : w_man_a;
      s1_man_s_d = w_swap ? w_man_a : w_man_b;
      s1_exp_d   = w_swap ? w_exp_b : w_exp_a;
      s1_diff_d  = w_swap ? (w_exp_b - w_exp_a) : (w_exp_a - w_exp_b);
      s1_sign_d  = w_swap ? in_b[FP_W-1] : in_a[FP_W-1];
      s1_sub_d   = in_a[FP_W-1] ^ in_b[FP_W-1];
      s1_spec_d  = (&w_fld_a) | (&w_fld_b);
   end

   // ---------------------------------------------------------------- handshake
   logic             s1_valid_q;
   logic [SIG_W-1:0] s1_man_l_q, s1_man_s_q;
   logic [EXP_W-1:0] s1_exp_q, s1_diff_q;
   logic             s1_sign_q, s1_sub_q, s1_spec_q;
   logic             out_valid_q;
   logic             w_s2_ready;

   assign w_s2_ready = !out_valid_q || out_ready;
   assign in_ready   = !s1_valid_q || w_s2_ready;

   // ---------------------------------------------------------------- stage 1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_man_l_q <= '0;
         s1_man_s_q <= '0;
         s1_exp_q   <= '0;
         s1_diff_q  <= '0;
         s1_sign_q  <= 1'b0;
         s1_sub_q   <= 1'b0;
         s1_spec_q  <= 1'b0;
      end else if (in_ready) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_man_l_q <= s1_man_l_d;
            s1_man_s_q <= s1_man_s_d;
            s1_exp_q   <= s1_exp_d;
            s1_diff_q  <= s1_diff_d;
            s1_sign_q  <= s1_sign_d;
            s1_sub_q   <= s1_sub_d;
            s1_spec_q  <= s1_spec_d;
         end
      end
   end

   // ---------------------------------------------------------------- align
   logic [EXT_W-1:0] w_ext, w_shifted, w_lost;
   logic [2:0]       w_grs;

   // Shifts of EXT_W or more empty the field, so everything lands in sticky
   always_comb begin
      w_ext     = {s1_man_s_q, 3'b000};
      w_shifted = w_ext >> s1_diff_q;
      w_lost    = w_ext & ~({EXT_W{1'b1}} << s1_diff_q);
      w_grs     = {w_shifted[2], w_shifted[1], w_shifted[0] | (|w_lost)};
   end

   // ---------------------------------------------------------------- stage 2
   logic [SIG_W-1:0] out_man_l_q, out_man_s_q;
   logic [2:0]       out_grs_q;
   logic [EXP_W-1:0] out_exp_q;
   logic             out_sign_q, out_sub_q, out_spec_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_man_l_q <= '0;
         out_man_s_q <= '0;
         out_grs_q   <= '0;
         out_exp_q   <= '0;
         out_sign_q  <= 1'b0;
         out_sub_q   <= 1'b0;
         out_spec_q  <= 1'b0;
      end else if (w_s2_ready) begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            out_man_l_q <= s1_man_l_q;
            out_man_s_q <= w_shifted[EXT_W-1:3];
            out_grs_q   <= w_grs;
            out_exp_q   <= s1_exp_q;
            out_sign_q  <= s1_sign_q;
            out_sub_q   <= s1_sub_q;
            out_spec_q  <= s1_spec_q;
         end
      end
   end

   assign out_valid      = out_valid_q;
   assign out_man_large  = out_man_l_q;
   assign out_man_small  = out_man_s_q;
   assign out_grs        = out_grs_q;
   assign out_exp        = out_exp_q;
   assign out_sign_large = out_sign_q;
   assign out_eff_sub    = out_sub_q;
   assign out_special    = out_spec_q;

endmodule
`default_nettype wire
